psum_output_packer: RTL
=======================

PSUM_OUTPUT_PACKER -- requirements
Module: psum_output_packer

Interface
REQ-001 Parameter BIT_WIDTH, default 8, width of one kernel psum.
REQ-002 Parameter NUM_KERNEL, default 4, kernel lanes packed per word; fixed at 4 in this revision.
REQ-003 Parameter REG_WIDTH, default 32, output word width; SHALL equal BIT_WIDTH*NUM_KERNEL.
REQ-004 Parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, >= 2.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset is asynchronous and active-low.
REQ-007 Ports i_psum_kn0..i_psum_kn3, input, BIT_WIDTH each, per-kernel psum from the accumulator.
REQ-008 Ports i_psum_kn0_val..i_psum_kn3_val, input, 1 each, per-kernel psum valid, single-cycle qualifier with no backpressure.
REQ-009 Port i_flush, input, 1, discards the partially collected lane set.
REQ-010 Port o_word, output, REG_WIDTH, packed word {kn3,kn2,kn1,kn0}, with kn0 in bits [7:0].
REQ-011 Port o_word_val, output, 1, FIFO non-empty.
REQ-012 Port i_word_rdy, input, 1, downstream ready.
REQ-013 Port o_fifo_cnt, output, log2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-014 Port o_ovf, output, 1, sticky flag: a complete word was dropped because the FIFO was full.
REQ-015 Port o_lane_err, output, 1, sticky flag: a lane valid was repeated before its set completed.
REQ-016 Port o_drop_cnt, output, 16, dropped-word counter (see Configuration).

Function
REQ-017 Per-lane capture register and lane mask; FSM states IDLE (mask 0) and COLLECT (mask non-zero and incomplete).
REQ-018 A lane with val=1 SHALL be captured at the clock edge; lanes may arrive in any order and across any number of cycles.
REQ-019 Set completes when the lane mask OR-ed with the current-cycle vals equals 4'b1111; current-cycle values SHALL bypass the capture registers into the packed word.
REQ-020 On completion, at the same edge: the word is pushed (if accepted), the mask is cleared, and the FSM returns to IDLE; all four vals high in IDLE produce a push directly.
REQ-021 If a lane val arrives while that lane's mask bit is set, the block SHALL overwrite the lane value and set o_lane_err.
REQ-022 If i_flush=1, the block SHALL clear the mask and go to IDLE; current-cycle vals are ignored; the FIFO is untouched; flush has priority over completion.
REQ-023 Pop occurs when o_word_val && i_word_rdy; o_word shows the FIFO head combinationally from the registered storage.
REQ-024 Latency: last lane val at edge N gives o_word_val=1 after edge N, provided the FIFO was empty.
REQ-025 Push when full with no pop: the word is dropped, o_ovf set, and the counter incremented.
REQ-026 Push when full with a simultaneous pop: the push SHALL be accepted and the count is unchanged.
REQ-027 Push and pop when empty: the push is stored, the pop does not occur (o_word_val was 0), and the count becomes 1.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_cnt ranges 0..FIFO_DEPTH.

Reset
REQ-029 While rst=0, the block SHALL hold: mask=0, FSM=IDLE, FIFO pointers and count 0, o_word_val=0, o_word=0, o_ovf=0, o_lane_err=0, o_drop_cnt=0.
REQ-030 Reset asserted mid-collection or with a full FIFO SHALL discard all contents immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro PSUM_PACKER_DROP_CNT_EN: when defined, o_drop_cnt counts dropped words and saturates at 16'hFFFF.
REQ-032 When PSUM_PACKER_DROP_CNT_EN is undefined, o_drop_cnt is tied to 0 and no counter flops exist; o_ovf behaviour is unchanged.

Structure
REQ-033 Shared package psum_pkg SHALL hold the BIT_WIDTH, NUM_KERNEL, REG_WIDTH and FIFO_DEPTH defaults and the FSM state encoding.
REQ-034 The FIFO SHALL be a sub-module named psum_sync_fifo (push/pop/full/empty/count, async active-low reset).

Verification
REQ-035 Vals kn0..kn3 all high in one cycle with values 0x11,0x22,0x33,0x44, and rdy=1 -> o_word=0x44332211, o_word_val high for 1 cycle, 1 cycle later.
REQ-036 kn2 (0xA0), then kn0 (0x01), then kn3 (0xB0), then kn1 (0x02) on successive cycles -> one word 0xB0A00201; no word earlier.
REQ-037 kn1=0x05 then kn1=0x06 then kn0, kn2, kn3 = 0 -> o_lane_err=1, word=0x00000600.
REQ-038 rdy=0, 9 complete sets with FIFO_DEPTH=8 -> o_fifo_cnt=8, o_ovf=1, o_drop_cnt=1 (0 if macro undefined); the 9th set then pushed with rdy=1 is accepted.
REQ-039 kn0 captured, then i_flush, then a full set 0xDDCCBBAA -> only 0xDDCCBBAA emitted; rst pulled low mid-collection -> outputs zero immediately.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared defaults and FSM encoding for the psum output packer.
package psum_pkg;

    localparam int unsigned BIT_WIDTH_DEF  = 8;
    localparam int unsigned NUM_KERNEL_DEF = 4;
    localparam int unsigned REG_WIDTH_DEF  = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned DROP_CNT_W     = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } pack_state_e;

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous power-of-two FIFO; a pop frees a slot for a same-cycle push when full.
module psum_sync_fifo
    import psum_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_q;
    // Storage is not reset; masking with empty keeps the head at zero after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/psum_output_packer.sv
// Collects four kernel psum lanes into one word and queues it for downstream.
// Optional macro PSUM_PACKER_DROP_CNT_EN enables the saturating dropped-word counter.
module psum_output_packer
    import psum_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
    parameter int unsigned NUM_KERNEL = NUM_KERNEL_DEF,
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_WIDTH-1:0]          i_psum_kn0,
    input  logic [BIT_WIDTH-1:0]          i_psum_kn1,
    input  logic [BIT_WIDTH-1:0]          i_psum_kn2,
    input  logic [BIT_WIDTH-1:0]          i_psum_kn3,
    input  logic                          i_psum_kn0_val,
    input  logic                          i_psum_kn1_val,
    input  logic                          i_psum_kn2_val,
    input  logic                          i_psum_kn3_val,
    input  logic                          i_flush,
    output logic [REG_WIDTH-1:0]          o_word,
    output logic                          o_word_val,
    input  logic                          i_word_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
    output logic                          o_ovf,
    output logic                          o_lane_err,
    output logic [DROP_CNT_W-1:0]         o_drop_cnt
);

    typedef logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] lanes_t;

    pack_state_e           state_q, state_d;
    logic [NUM_KERNEL-1:0] mask_q, mask_d, vals, merged;
    lanes_t                lane_q, lane_d, psum_in;
    logic                  push_c, err_set_c, pop_c, drop_c;
    logic                  fifo_full, fifo_empty;

    assign vals    = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};
    assign psum_in = {i_psum_kn3, i_psum_kn2, i_psum_kn1, i_psum_kn0};

    // Lane merge: current-cycle values bypass into the pushed word via lane_d.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        lane_d    = lane_q;
        merged    = mask_q;
        push_c    = 1'b0;
        err_set_c = 1'b0;
        if (i_flush) begin
            mask_d  = '0;
            state_d = ST_IDLE;
        end else begin
            for (int k = 0; k < NUM_KERNEL; k++) begin
                if (vals[k]) lane_d[k] = psum_in[k];
            end
            err_set_c = |(mask_q & vals);
            unique case (state_q)
                ST_IDLE: merged = vals;
                default: merged = mask_q | vals;
            endcase
            if (&merged) begin
                push_c  = 1'b1;
                mask_d  = '0;
                state_d = ST_IDLE;
            end else begin
                mask_d  = merged;
                state_d = (|merged) ? ST_COLLECT : ST_IDLE;
            end
        end
    end

    assign pop_c  = o_word_val && i_word_rdy;
    assign drop_c = push_c && fifo_full && !pop_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            lane_q     <= '0;
            o_lane_err <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
            if (err_set_c) o_lane_err <= 1'b1;
            if (drop_c)    o_ovf      <= 1'b1;
        end
    end

`ifdef PSUM_PACKER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else if (drop_c && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

    assign o_word_val = !fifo_empty;

    psum_sync_fifo #(
        .WIDTH (REG_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (REG_WIDTH'(lane_d)),
        .pop   (pop_c),
        .rdata (o_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_cnt)
    );

endmodule
